// File: rtl/mem_wr.sv
// Frame-buffer write engine: drains the capture FIFO into BRAM port A,
// storing exactly one frame at addresses 0..BRAM_DEPTH-1 per start pulse.
module mem_wr #(
  parameter  int BRAM_DEPTH = 16384,
  parameter  int DATA_WIDTH = 12,
  localparam int AW         = $clog2(BRAM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_empty,
  output logic                  o_rd,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_wr,
  output logic [AW-1:0]         o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CW = AW + 1;

  localparam logic [CW-1:0] RD_FULL   = CW'(BRAM_DEPTH);
  localparam logic [CW-1:0] RD_LAST   = CW'(BRAM_DEPTH - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(BRAM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [AW-1:0]         waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd;

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wptr_d   = wptr_q;
    wr_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rd       = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d  = ACTIVE;
          rd_cnt_d = '0;
          wptr_d   = '0;
        end
      end
      ACTIVE: begin
        // Holding the strobe low during reset keeps the FIFO from losing a word
        // whose write would be discarded anyway.
        rd = !i_empty && (rd_cnt_q != RD_FULL) && !i_rst;
        if (rd) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
          if (rd_cnt_q == RD_LAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The first DRAIN cycle always carries the final read in flight; once it
        // has moved into the write stage the frame is complete.
        if (!rd_q && wr_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rd_d = rd;

    if (rd_q) begin
      wr_d    = 1'b1;
      waddr_d = wptr_q;
      wdata_d = i_rdata;
      wptr_d  = (wptr_q == ADDR_LAST) ? '0 : wptr_q + AW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      rd_cnt_q <= '0;
      wptr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wptr_q   <= wptr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign o_rd    = rd;
  assign o_wr    = wr_q;
  assign o_waddr = waddr_q;
  assign o_wdata = wdata_q;
  assign o_busy  = (state_q == ACTIVE) || (state_q == DRAIN);
  assign o_done  = (state_q == DONE);

endmodule

// File: tb/tb_mem_wr.sv
// Self-checking bench for mem_wr: FIFO model feeds the DUT, a scoreboard queue
// holds the expected BRAM writes and a negedge monitor compares them.
module tb_mem_wr;

  localparam int DEPTH = 16;
  localparam int DW    = 12;
  localparam int AW    = $clog2(DEPTH);

  logic          i_clk   = 1'b0;
  logic          i_rst   = 1'b1;
  logic          i_start = 1'b0;
  logic          i_empty;
  logic          o_rd;
  logic [DW-1:0] i_rdata = '0;
  logic          o_wr;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  logic          o_busy;
  logic          o_done;

  mem_wr #(.BRAM_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(i_start),
    .i_empty(i_empty),
    .o_rd   (o_rd),
    .i_rdata(i_rdata),
    .o_wr   (o_wr),
    .o_waddr(o_waddr),
    .o_wdata(o_wdata),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic [DW-1:0] fifo_mem [0:63];
  int            fifo_wr     = 0;
  int            fifo_rd     = 0;
  logic          fifo_clear  = 1'b0;
  logic          force_empty = 1'b0;
  int            frame_base  = 0;

  wr_t  exp_q[$];
  int   tests        = 0;
  int   fails        = 0;
  int   rd_count     = 0;
  int   done_count   = 0;
  int   cyc          = 0;
  int   start_cyc    = 0;
  int   wr_cyc [DEPTH];
  logic last_wr_prev = 1'b0;

  assign i_empty = force_empty || (fifo_rd >= fifo_wr);

  // FIFO with one cycle of read latency
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (fifo_clear) begin
      fifo_rd <= 0;
    end else if (o_rd) begin
      i_rdata <= (fifo_rd < fifo_wr) ? fifo_mem[fifo_rd[5:0]] : '0;
      fifo_rd <= fifo_rd + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge i_clk) begin
    wr_t e;
    if (o_rd) begin
      rd_count++;
      checkOutput("rd_while_empty", 32'(i_empty), 32'd0);
    end
    if (o_wr) begin
      wr_cyc[o_waddr] = cyc;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_write: addr %0d data %0h, expected no write (cycle %0d)",
                 o_waddr, o_wdata, cyc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(o_waddr), 32'(e.addr));
        checkOutput("wr_data", 32'(o_wdata), 32'(e.data));
      end
    end
    checkOutput("done_timing", 32'(o_done), 32'(last_wr_prev));
    if (o_done) begin
      done_count++;
      checkOutput("busy_in_done", 32'(o_busy), 32'd0);
    end
    last_wr_prev = o_wr && (o_waddr == AW'(DEPTH - 1));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  task automatic pushWord(input logic [DW-1:0] d);
    fifo_mem[fifo_wr[5:0]] = d;
    fifo_wr++;
  endtask

  task automatic fifoReset();
    fifo_clear = 1'b1;
    tick();
    fifo_clear = 1'b0;
    fifo_wr    = 0;
    frame_base = 0;
  endtask

  // A frame consumes the next DEPTH FIFO words, written to addresses 0,1,...
  task automatic applyStimulus(input int nexp);
    wr_t e;
    for (int k = 0; k < nexp; k++) begin
      e.addr = AW'(k);
      e.data = fifo_mem[6'(frame_base + k)];
      exp_q.push_back(e);
    end
    frame_base += DEPTH;
    start_cyc = cyc;
    i_start   = 1'b1;
    tick();
    i_start   = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    int d0 = done_count;
    int n  = 0;
    while (done_count == d0 && n < limit) begin
      tick();
      n++;
    end
    checkOutput("done_timeout", 32'(done_count != d0), 32'd1);
  endtask

  task automatic waitReads(input int base, input int nreads, input int limit);
    int n = 0;
    while ((rd_count - base) < nreads && n < limit) begin
      tick();
      n++;
    end
    checkOutput("read_timeout", 32'((rd_count - base) >= nreads), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rd0, d0, w0;

    tick(3);
    checkOutput("reset_wr", 32'(o_wr), 32'd0);
    checkOutput("reset_waddr", 32'(o_waddr), 32'd0);
    checkOutput("reset_wdata", 32'(o_wdata), 32'd0);
    checkOutput("reset_busy", 32'(o_busy), 32'd0);
    checkOutput("reset_done", 32'(o_done), 32'd0);
    checkOutput("reset_rd", 32'(o_rd), 32'd0);
    i_rst = 1'b0;
    tick(2);

    // Basic frame of 0..15
    for (int k = 0; k < DEPTH; k++) pushWord(DW'(k));
    rd0 = rd_count;
    d0  = done_count;
    applyStimulus(DEPTH);
    checkOutput("busy_rise", 32'(o_busy), 32'd1);
    waitDone(100);
    checkOutput("busy_fall", 32'(o_busy), 32'd0);
    checkOutput("first_wr_latency", 32'(wr_cyc[0] - start_cyc), 32'd3);
    checkOutput("frame1_span", 32'(wr_cyc[DEPTH-1] - wr_cyc[0]), 32'(DEPTH - 1));
    tick(5);
    checkOutput("frame1_reads", 32'(rd_count - rd0), 32'(DEPTH));
    checkOutput("frame1_done_once", 32'(done_count - d0), 32'd1);
    checkOutput("frame1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Stall for 5 cycles after the 6th read
    for (int k = 0; k < DEPTH; k++) pushWord(DW'(k));
    rd0 = rd_count;
    d0  = done_count;
    applyStimulus(DEPTH);
    waitReads(rd0, 6, 50);
    force_empty = 1'b1;
    tick(3);
    checkOutput("stall_no_wr", 32'(o_wr), 32'd0);
    checkOutput("stall_reads", 32'(rd_count - rd0), 32'd6);
    tick(2);
    force_empty = 1'b0;
    waitDone(100);
    tick(5);
    checkOutput("stall_reads_total", 32'(rd_count - rd0), 32'(DEPTH));
    checkOutput("stall_done_once", 32'(done_count - d0), 32'd1);
    checkOutput("stall_sb_empty", 32'(exp_q.size()), 32'd0);

    // FIFO holds 20 words; only one frame is taken
    for (int k = 0; k < 20; k++) pushWord(DW'(12'h100 + k));
    rd0 = rd_count;
    applyStimulus(DEPTH);
    waitDone(100);
    tick(10);
    checkOutput("extra_reads", 32'(rd_count - rd0), 32'(DEPTH));
    checkOutput("extra_left", 32'(fifo_wr - fifo_rd), 32'd4);
    checkOutput("extra_rd_low", 32'(o_rd), 32'd0);

    // Reset one cycle after the read of word 8
    fifoReset();
    for (int k = 0; k < DEPTH; k++) pushWord(DW'(12'h200 + k));
    rd0 = rd_count;
    d0  = done_count;
    applyStimulus(8);
    waitReads(rd0, 9, 50);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checkOutput("rst_wr", 32'(o_wr), 32'd0);
    checkOutput("rst_waddr", 32'(o_waddr), 32'd0);
    checkOutput("rst_wdata", 32'(o_wdata), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_done", 32'(o_done), 32'd0);
    checkOutput("rst_rd", 32'(o_rd), 32'd0);
    tick(5);
    checkOutput("rst_no_done", 32'(done_count - d0), 32'd0);
    checkOutput("rst_sb_empty", 32'(exp_q.size()), 32'd0);
    fifoReset();
    for (int k = 0; k < DEPTH; k++) pushWord(DW'(12'h300 + k));
    applyStimulus(DEPTH);
    waitDone(100);
    checkOutput("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

    // Spurious starts during ACTIVE and in the DONE cycle
    fifoReset();
    for (int k = 0; k < DEPTH; k++) pushWord(DW'(12'h400 + k));
    d0 = done_count;
    applyStimulus(DEPTH);
    tick(4);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    w0 = 0;
    while (!o_done && w0 < 100) begin
      tick();
      w0++;
    end
    checkOutput("wait_done_cycle", 32'(o_done), 32'd1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick(10);
    checkOutput("ignored_start_busy", 32'(o_busy), 32'd0);
    checkOutput("ignored_start_done_once", 32'(done_count - d0), 32'd1);
    for (int k = 0; k < DEPTH; k++) pushWord(DW'(12'h500 + k));
    applyStimulus(DEPTH);
    waitDone(100);
    checkOutput("second_frame_sb_empty", 32'(exp_q.size()), 32'd0);

    // Two random frames back to back
    fifoReset();
    for (int k = 0; k < 2 * DEPTH; k++) pushWord(DW'($urandom_range(0, 4095)));
    rd0 = rd_count;
    applyStimulus(DEPTH);
    waitDone(100);
    checkOutput("rand_f1_span", 32'(wr_cyc[DEPTH-1] - wr_cyc[0]), 32'(DEPTH - 1));
    applyStimulus(DEPTH);
    waitDone(100);
    checkOutput("rand_f2_span", 32'(wr_cyc[DEPTH-1] - wr_cyc[0]), 32'(DEPTH - 1));
    checkOutput("rand_reads", 32'(rd_count - rd0), 32'(2 * DEPTH));
    checkOutput("rand_sb_empty", 32'(exp_q.size()), 32'd0);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_wr.md
Name: mem_wr

Overview:
- Write-side companion of the frame-buffer read engine: drains a pixel FIFO and stores exactly one frame (BRAM_DEPTH words) into BRAM at addresses 0..BRAM_DEPTH-1.
- Armed by a start pulse. Signals frame completion so the read engine can be requested.
- Sits between the capture FIFO (read port) and BRAM port A (write-only).

Parameters:
- BRAM_DEPTH, 16384, words per frame; also the BRAM depth. Address width AW = $clog2(BRAM_DEPTH).
- DATA_WIDTH, 12, pixel word width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  one-cycle pulse; arms capture of one frame. Honoured only in IDLE.
- i_empty  in  1  FIFO empty flag.
- o_rd  out  1  FIFO read strobe. Combinational. FIFO data is valid on i_rdata the next cycle.
- i_rdata  in  DATA_WIDTH  FIFO read data.
- o_wr  out  1  BRAM write enable. Registered.
- o_waddr  out  AW  BRAM write address. Registered.
- o_wdata  out  DATA_WIDTH  BRAM write data. Registered.
- o_busy  out  1  high while in ACTIVE or DRAIN.
- o_done  out  1  one-cycle pulse after the last BRAM write of a frame.

Behaviour:
- Reset state: o_wr=0, o_waddr=0, o_wdata=0, o_done=0, o_busy=0, state=IDLE. Read count and in-flight flag are cleared.
- Reset mid-frame: returns to IDLE on the next edge. An outstanding FIFO read is discarded and no write is issued for it. Frame is abandoned; o_done does not fire.
- States:
  - IDLE: o_rd=0. i_start=1 -> ACTIVE; read count rd_cnt=0, write pointer wptr=0.
  - ACTIVE: o_rd = !i_empty && (rd_cnt != BRAM_DEPTH). Each o_rd increments rd_cnt. When a read is issued with rd_cnt==BRAM_DEPTH-1 -> DRAIN.
  - DRAIN: o_rd=0. Wait for the final in-flight word to be written, then -> DONE.
  - DONE: o_done=1 for exactly one cycle, then -> IDLE.
- Pipeline and latency:
  - o_rd high in cycle n -> flag rd_q=1 in cycle n+1, i_rdata sampled at edge n+1->n+2.
  - In cycle n+2: o_wr=1, o_wdata = sampled word, o_waddr = wptr. wptr then increments.
  - Read-strobe to BRAM-write latency is 2 cycles.
- Back-to-back reads (o_rd high every cycle) give back-to-back writes with contiguous addresses and no gaps.
- o_wr is 0 on every cycle without a preceding valid read. o_waddr and o_wdata hold their last values when o_wr=0.
- Addresses are strictly 0,1,...,BRAM_DEPTH-1 in order, one write per word. wptr wraps to 0 after BRAM_DEPTH-1, ready for the next frame.
- i_empty toggling mid-frame only stalls reads. No word is dropped or duplicated.
- i_start outside IDLE is ignored, including in the DONE cycle.
- i_start and i_empty=0 in the same IDLE cycle: no read in that cycle. The first read can occur in the following cycle.
- Exactly BRAM_DEPTH reads per frame. The FIFO is never read beyond that, even if non-empty.
- o_done timing: asserted in the cycle after o_wr with o_waddr=BRAM_DEPTH-1.
- o_busy timing: rises the cycle after i_start is accepted; falls in the DONE cycle.

Test Plan:
- BRAM_DEPTH=16, FIFO preloaded with 16 words 0x000..0x00F, pulse i_start -> 16 consecutive o_wr cycles with addr k / data k. First o_wr comes 3 cycles after i_start. o_done pulses once, the cycle after addr 15. Exactly 16 o_rd pulses.
- Same setup, i_empty forced high for 5 cycles after the 6th read -> writes pause, then resume at addr 6 with data 0x006. No duplicate or missing address; o_done still fires once.
- FIFO holds 20 words, one frame of 16 -> exactly 16 reads. 4 words remain in the FIFO; o_rd stays 0 after DRAIN.
- i_rst asserted 1 cycle after the read of word 8 -> no o_wr for word 8. All outputs 0 next cycle, o_done never pulses. A new i_start then writes from addr 0.
- i_start pulsed during ACTIVE and in the DONE cycle -> ignored: a single frame, single o_done. A second i_start in IDLE writes a second frame starting at addr 0.
- Continuous i_empty=0 with random data, two frames back-to-back -> scoreboard: BRAM contents equal the FIFO stream in order. Throughput is 1 write/cycle during ACTIVE.
